llc_req_frontend: RTL and testbench



---
 rtl/llc_req_frontend.sv | 156 +++++++++++++++
 tb/tb_llc_req_frontend.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_req_frontend.sv
// llc_req_frontend
//
// Request front-end for the 16 MB, 16-way, 64 B-line last-level cache.
// Trace commands (opcode + byte address) are accepted over a valid/ready
// handshake. Illegal opcodes (10-15) are consumed and dropped. Legal ones
// (0-9) are split into tag/index/offset and queued in a circular FIFO. The
// FIFO head is presented to the lookup/PLRU stage over a second valid/ready
// handshake.
//
// Optional feature macro: LLC_REQ_STATS_EN
//   defined     -> per-opcode saturating statistics counters plus stats_clr
//   not defined -> no counter registers; counter outputs tie to 0 and
//                  stats_clr is ignored
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  statistics counter width
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       upstream request handshake
//   in_op, in_addr          trace opcode and 32-bit byte address
//   out_valid/out_ready     lookup-stage handshake for the FIFO head
//   out_op, out_tag,
//   out_index, out_offset   head request fields (zero while empty)
//   level                   current FIFO occupancy
//   stats_clr               synchronous clear of all counters
//   cnt_read                dequeued ops 0 and 2
//   cnt_write               dequeued op 1
//   cnt_illegal             accepted requests with opcode > 9
module llc_req_frontend #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_op,
  input  logic [31:0]                in_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_op,
  output logic [11:0]                out_tag,
  output logic [13:0]                out_index,
  output logic [5:0]                 out_offset,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       stats_clr,
  output logic [CNT_W-1:0]           cnt_read,
  output logic [CNT_W-1:0]           cnt_write,
  output logic [CNT_W-1:0]           cnt_illegal
);

  localparam int TAG_BITS          = 12;
  localparam int INDEX_BITS        = 14;
  localparam int BLOCK_OFFSET_BITS = 6;
  localparam int PTR_W             = $clog2(DEPTH);
  localparam int LVL_W             = PTR_W + 1;

  logic [3:0]                   op_mem  [DEPTH];
  logic [TAG_BITS-1:0]          tag_mem [DEPTH];
  logic [INDEX_BITS-1:0]        idx_mem [DEPTH];
  logic [BLOCK_OFFSET_BITS-1:0] off_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic accept;
  logic legal;
  logic enq;
  logic deq;
  logic illegal_acc;

  // Handshake signals derive from the registered level only, so in_ready
  // never depends on out_ready and a full FIFO cannot enqueue even while
  // it is being drained in the same cycle.
  assign in_ready    = (level != LVL_W'(DEPTH));
  assign out_valid   = (level != '0);
  assign accept      = in_valid && in_ready;
  assign legal       = (in_op <= 4'd9);
  assign enq         = accept && legal;
  assign illegal_acc = accept && !legal;
  assign deq         = out_valid && out_ready;

  // Head fields are masked while empty so the outputs read zero after reset
  // without having to reset the storage array.
  assign out_op     = out_valid ? op_mem[rd_ptr]  : '0;
  assign out_tag    = out_valid ? tag_mem[rd_ptr] : '0;
  assign out_index  = out_valid ? idx_mem[rd_ptr] : '0;
  assign out_offset = out_valid ? off_mem[rd_ptr] : '0;

  // Storage array: the address split is pure bit-slicing at enqueue time.
  always_ff @(posedge clk) begin
    if (enq) begin
      op_mem[wr_ptr]  <= in_op;
      tag_mem[wr_ptr] <= in_addr[31:20];
      idx_mem[wr_ptr] <= in_addr[19:6];
      off_mem[wr_ptr] <= in_addr[5:0];
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; level is kept in
  // its own register so full and empty are unambiguous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef LLC_REQ_STATS_EN
  logic read_hit;
  logic write_hit;

  assign read_hit  = deq && ((out_op == 4'd0) || (out_op == 4'd2));
  assign write_hit = deq && (out_op == 4'd1);

  // Saturating counters; a clear takes priority over any increment in the
  // same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_read    <= '0;
      cnt_write   <= '0;
      cnt_illegal <= '0;
    end else if (stats_clr) begin
      cnt_read    <= '0;
      cnt_write   <= '0;
      cnt_illegal <= '0;
    end else begin
      if (read_hit && (cnt_read != '1))
        cnt_read <= cnt_read + CNT_W'(1);
      if (write_hit && (cnt_write != '1))
        cnt_write <= cnt_write + CNT_W'(1);
      if (illegal_acc && (cnt_illegal != '1))
        cnt_illegal <= cnt_illegal + CNT_W'(1);
    end
  end
`else
  logic unused_stats;

  assign cnt_read     = '0;
  assign cnt_write    = '0;
  assign cnt_illegal  = '0;
  assign unused_stats = stats_clr ^ illegal_acc;
`endif

endmodule

// File: tb/tb_llc_req_frontend.sv
// tb_llc_req_frontend
//
// Directed-vector bench for llc_req_frontend (DEPTH=8, CNT_W=4). Expected
// counter values depend on whether LLC_REQ_STATS_EN is defined; without it
// every counter must read zero.
module tb_llc_req_frontend;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
`ifdef LLC_REQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [31:0]       in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_op;
  logic [11:0]       out_tag;
  logic [13:0]       out_index;
  logic [5:0]        out_offset;
  logic [3:0]        level;
  logic              stats_clr;
  logic [CNT_W-1:0]  cnt_read;
  logic [CNT_W-1:0]  cnt_write;
  logic [CNT_W-1:0]  cnt_illegal;

  int checks = 0;
  int errors = 0;

  logic [3:0]  exp_op   [0:8];
  logic [31:0] exp_addr [0:8];

  llc_req_frontend #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
    .level(level), .stats_clr(stats_clr),
    .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_illegal(cnt_illegal)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one upstream request (held until changed by the caller).
  task automatic applyStimulus(input logic valid, input logic [3:0] op,
                               input logic [31:0] addr);
    in_valid = valid;
    in_op    = op;
    in_addr  = addr;
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cntExp(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    stats_clr = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0);
    stepCycle();

    // Reset state
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_op", 32'(out_op), 32'd0);
    checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
    checkOutput("rst_out_index", 32'(out_index), 32'd0);
    checkOutput("rst_out_offset", 32'(out_offset), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_cnt_read", 32'(cnt_read), 32'd0);
    checkOutput("rst_cnt_illegal", 32'(cnt_illegal), 32'd0);
    rst_n = 1'b1;
    stepCycle();

    // Field split, no bypass on empty + enqueue
    out_ready = 1'b1;
    applyStimulus(1'b1, 4'd0, 32'h1234_5678);
    #1;
    checkOutput("split_no_bypass", 32'(out_valid), 32'd0);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 32'd0);
    checkOutput("split_valid", 32'(out_valid), 32'd1);
    checkOutput("split_tag", 32'(out_tag), 32'h123);
    checkOutput("split_index", 32'(out_index), 32'h1159);
    checkOutput("split_offset", 32'(out_offset), 32'h38);
    checkOutput("split_op", 32'(out_op), 32'd0);
    stepCycle();
    checkOutput("split_drained", 32'(level), 32'd0);
    checkOutput("split_cnt_read", 32'(cnt_read), cntExp(1));

    // Illegal opcode is consumed but not queued
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'd12, 32'hFFFF_FFFF);
    #1;
    checkOutput("ill_in_ready", 32'(in_ready), 32'd1);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 32'd0);
    checkOutput("ill_level", 32'(level), 32'd0);
    checkOutput("ill_out_valid", 32'(out_valid), 32'd0);
    checkOutput("ill_cnt", 32'(cnt_illegal), cntExp(1));

    // Fill and drain: 9 legal requests against an 8-entry FIFO
    for (int i = 0; i < 9; i++) begin
      exp_op[i]   = 4'(i);
      exp_addr[i] = 32'hA000_0000 + 32'(i) * 32'h0010_0041;
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, exp_op[i], exp_addr[i]);
      checkOutput($sformatf("fill_ready_%0d", i), 32'(in_ready), 32'd1);
      stepCycle();
    end
    applyStimulus(1'b1, exp_op[8], exp_addr[8]);
    checkOutput("full_level", 32'(level), 32'd8);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    stepCycle();
    checkOutput("full_hold_level", 32'(level), 32'd8);
    checkOutput("full_head_op", 32'(out_op), 32'(exp_op[0]));
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput("full_deq_level", 32'(level), 32'd7);
    checkOutput("full_deq_ready", 32'(in_ready), 32'd1);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 32'd0);
    checkOutput("refill_level", 32'(level), 32'd8);
    out_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      checkOutput($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("drain_op_%0d", i), 32'(out_op), 32'(exp_op[i]));
      checkOutput($sformatf("drain_tag_%0d", i), 32'(out_tag), 32'(exp_addr[i][31:20]));
      checkOutput($sformatf("drain_idx_%0d", i), 32'(out_index), 32'(exp_addr[i][19:6]));
      checkOutput($sformatf("drain_off_%0d", i), 32'(out_offset), 32'(exp_addr[i][5:0]));
      stepCycle();
    end
    checkOutput("drain_empty", 32'(level), 32'd0);
    checkOutput("drain_cnt_read", 32'(cnt_read), cntExp(3));
    checkOutput("drain_cnt_write", 32'(cnt_write), cntExp(1));

    // Simultaneous enqueue/dequeue at level 3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'(3 + i), 32'h0000_1000 * 32'(i + 1));
      stepCycle();
    end
    checkOutput("sim_level_pre", 32'(level), 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'((6 + i) % 10 + ((6 + i) >= 10 ? 3 : 0)), 32'h0000_2000);
      checkOutput($sformatf("sim_head_%0d", i), 32'(out_op), 32'(3 + i));
      stepCycle();
      checkOutput($sformatf("sim_level_%0d", i), 32'(level), 32'd3);
    end
    applyStimulus(1'b0, 4'd0, 32'd0);
    checkOutput("sim_tail_a", 32'(out_op), 32'd8);
    stepCycle();
    checkOutput("sim_tail_b", 32'(out_op), 32'd9);
    stepCycle();
    checkOutput("sim_tail_c", 32'(out_op), 32'd3);
    stepCycle();
    checkOutput("sim_empty", 32'(level), 32'd0);

    // Write counter saturation: 16 more writes on top of 1
    applyStimulus(1'b1, 4'd1, 32'h0BAD_0000);
    for (int i = 0; i < 16; i++) stepCycle();
    applyStimulus(1'b0, 4'd0, 32'd0);
    stepCycle();
    checkOutput("sat_level", 32'(level), 32'd0);
    checkOutput("sat_cnt_write", 32'(cnt_write), cntExp(15));
    checkOutput("sat_cnt_read", 32'(cnt_read), cntExp(3));

    // Clear wins over a simultaneous write dequeue
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'd1, 32'h0000_0040);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 32'd0);
    out_ready = 1'b1;
    stats_clr = 1'b1;
    stepCycle();
    stats_clr = 1'b0;
    out_ready = 1'b0;
    checkOutput("clr_level", 32'(level), 32'd0);
    checkOutput("clr_cnt_write", 32'(cnt_write), 32'd0);
    checkOutput("clr_cnt_read", 32'(cnt_read), 32'd0);
    checkOutput("clr_cnt_illegal", 32'(cnt_illegal), 32'd0);

    // Asynchronous reset with 5 requests queued
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'd1, 32'h5555_0000 + 32'(i));
      stepCycle();
    end
    applyStimulus(1'b0, 4'd0, 32'd0);
    checkOutput("mid_level_pre", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_level", 32'(level), 32'd0);
    checkOutput("mid_in_ready", 32'(in_ready), 32'd1);
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd2, 32'hDEAD_BEEF);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 32'd0);
    checkOutput("post_valid", 32'(out_valid), 32'd1);
    checkOutput("post_level", 32'(level), 32'd1);
    checkOutput("post_op", 32'(out_op), 32'd2);
    checkOutput("post_tag", 32'(out_tag), 32'hDEA);
    checkOutput("post_index", 32'(out_index), 32'h36FB);
    checkOutput("post_offset", 32'(out_offset), 32'h2F);
    out_ready = 1'b1;
    stepCycle();
    checkOutput("post_cnt_read", 32'(cnt_read), cntExp(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
